lsu_multi_lane: RTL and testbench

// - Multi-lane load/store unit for one SIMD core: NUM_LANES lanes share a single data-memory port.
// - Per-lane FSM (IDLE/REQUESTING/WAITING/DONE); round-robin arbiter serialises lane requests onto the port.
// - Lane mask disables lanes. Aggregate done flag lets the SIMD controller leave its WAIT phase.
// - Sits between the SIMD controller/register files and the data-memory controller.

---
 rtl/lsu_multi_lane_pkg.sv | 23 ++
 rtl/lsu_multi_lane_lane.sv | 72 +++++++
 rtl/lsu_multi_lane.sv | 148 ++++++++++++++
 tb/tb_lsu_multi_lane.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_multi_lane_pkg.sv
// Shared definitions for the multi-lane load/store unit.
// Contents:
//   lsu_state_e  - per-lane state encoding, also the value driven on lsu_state
//   SIMD_*       - SIMD controller phase codes seen on simd_state
package lsu_multi_lane_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_e;

  localparam logic [2:0] SIMD_IDLE    = 3'd0;
  localparam logic [2:0] SIMD_FETCH   = 3'd1;
  localparam logic [2:0] SIMD_DECODE  = 3'd2;
  localparam logic [2:0] SIMD_REQUEST = 3'd3;
  localparam logic [2:0] SIMD_WAIT    = 3'd4;
  localparam logic [2:0] SIMD_EXECUTE = 3'd5;
  localparam logic [2:0] SIMD_UPDATE  = 3'd6;
  localparam logic [2:0] SIMD_DONE    = 3'd7;

endpackage

// File: rtl/lsu_multi_lane_lane.sv
// One load/store lane: state machine plus the lane's load result register.
//
// state          | meaning
// ---------------+-------------------------------------------------------
// LSU_IDLE       | no memory op pending for this lane
// LSU_REQUESTING | waiting for the shared port to be granted
// LSU_WAITING    | transaction on the port, waiting for the memory ack
// LSU_DONE       | op complete, held until the SIMD controller moves on
//
// Ports:
//   clk, rst       clock, async active-low reset
//   enable         0 freezes state and read_out
//   start          request to leave IDLE (already qualified by lane mask and op)
//   retire         DONE -> IDLE
//   grant          this lane owns the port from the next edge
//   ack_hit        the outstanding transaction (owned by this lane) completed
//   ack_is_load    completing transaction was a load
//   read_data      memory read data
//   req            lane is REQUESTING
//   state          current state
//   state_next     state after the coming edge (used for the aggregate done flag)
//   read_out       last load result of this lane
module lsu_multi_lane_lane
  import lsu_multi_lane_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  retire,
  input  logic                  grant,
  input  logic                  ack_hit,
  input  logic                  ack_is_load,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  req,
  output logic [1:0]            state,
  output logic [1:0]            state_next,
  output logic [DATA_WIDTH-1:0] read_out
);

  lsu_state_e state_q, state_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LSU_IDLE;
    else      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      LSU_IDLE:       if (start)   state_nxt = LSU_REQUESTING;
      LSU_REQUESTING: if (grant)   state_nxt = LSU_WAITING;
      LSU_WAITING:    if (ack_hit) state_nxt = LSU_DONE;
      LSU_DONE:       if (retire)  state_nxt = LSU_IDLE;
      default:                     state_nxt = LSU_IDLE;
    endcase
    // Freeze lives here so state_next also reflects it.
    if (!enable) state_nxt = state_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   read_out <= '0;
    else if (enable && ack_hit && ack_is_load)  read_out <= read_data;
  end

  assign req        = (state_q == LSU_REQUESTING);
  assign state      = state_q;
  assign state_next = state_nxt;

endmodule

// File: rtl/lsu_multi_lane.sv
// Multi-lane load/store unit: NUM_LANES lanes share one data-memory port.
// A round-robin arbiter serialises lane requests; only one transaction is
// ever outstanding. lsu_done tells the SIMD controller all active lanes finished.
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   enable                        0 freezes all state and outputs
//   simd_state                    SIMD controller phase (REQUEST starts, UPDATE retires)
//   mem_read / mem_write          op select, load wins when both set
//   lane_mask                     1 = lane takes part
//   rm_data / rn_data             per-lane address / store data, lane i in slice i
//   mem_read_ack / mem_write_ack  memory completion, sampled only while matching valid is high
//   mem_read_data                 load data, valid with mem_read_ack
//   mem_read_valid / mem_write_valid, mem_addr, mem_write_data   memory request
//   lsu_state                     2 bits per lane
//   lsu_read_out                  per-lane load result
//   lsu_done                      every active lane is DONE
module lsu_multi_lane
  import lsu_multi_lane_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [2:0]                      simd_state,
  input  logic                            mem_read,
  input  logic                            mem_write,
  input  logic [NUM_LANES-1:0]            lane_mask,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] rm_data,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] rn_data,
  input  logic                            mem_read_ack,
  input  logic                            mem_write_ack,
  input  logic [DATA_WIDTH-1:0]           mem_read_data,
  output logic                            mem_read_valid,
  output logic                            mem_write_valid,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_write_data,
  output logic [NUM_LANES*2-1:0]          lsu_state,
  output logic [NUM_LANES*DATA_WIDTH-1:0] lsu_read_out,
  output logic                            lsu_done
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [LW-1:0]         ptr_q, owner_q, grant_idx;
  logic                  grant_any, bus_free, op_active, start_all, retire_all;
  logic                  ack_fire, done_nxt, any_busy, all_done;
  logic [NUM_LANES-1:0]  req, grant_vec, ack_hit_vec;
  logic [1:0]            st     [NUM_LANES];
  logic [1:0]            st_nxt [NUM_LANES];
  logic [ADDR_WIDTH-1:0] rm_lane [NUM_LANES];
  logic [DATA_WIDTH-1:0] rn_lane [NUM_LANES];

  // Lane index p+k wrapped into 0..NUM_LANES-1 (k < NUM_LANES).
  function automatic logic [LW-1:0] lane_add(input logic [LW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_LANES) s = s - NUM_LANES;
    return LW'(s);
  endfunction

  assign op_active  = mem_read | mem_write;
  assign start_all  = (simd_state == SIMD_REQUEST) && op_active;
  assign retire_all = (simd_state == SIMD_UPDATE);
  assign bus_free   = !mem_read_valid && !mem_write_valid;
  // Mismatched acks and acks with no request outstanding never fire.
  assign ack_fire   = (mem_read_valid && mem_read_ack) || (mem_write_valid && mem_write_ack);

  // First REQUESTING lane at or after the pointer, searched circularly.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!grant_any && req[lane_add(ptr_q, k)]) begin
        grant_any = 1'b1;
        grant_idx = lane_add(ptr_q, k);
      end
    end
    if (!(enable && bus_free && op_active)) grant_any = 1'b0;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign rm_lane[i]     = rm_data[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign rn_lane[i]     = rn_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign grant_vec[i]   = grant_any && (grant_idx == LW'(i));
    assign ack_hit_vec[i] = ack_fire && (owner_q == LW'(i));

    lsu_multi_lane_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .start       (start_all && lane_mask[i]),
      .retire      (retire_all),
      .grant       (grant_vec[i]),
      .ack_hit     (ack_hit_vec[i]),
      .ack_is_load (mem_read_valid),
      .read_data   (mem_read_data),
      .req         (req[i]),
      .state       (st[i]),
      .state_next  (st_nxt[i]),
      .read_out    (lsu_read_out[i*DATA_WIDTH +: DATA_WIDTH])
    );

    assign lsu_state[i*2 +: 2] = st[i];
  end

  // lsu_done is registered from the lanes' next states so it rises on the
  // same edge as the last lane reaches DONE.
  always_comb begin
    any_busy = 1'b0;
    all_done = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (st_nxt[i] != LSU_IDLE) any_busy = 1'b1;
      if (!((st_nxt[i] == LSU_DONE) || ((st_nxt[i] == LSU_IDLE) && !lane_mask[i])))
        all_done = 1'b0;
    end
    done_nxt = any_busy && all_done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_read_valid  <= 1'b0;
      mem_write_valid <= 1'b0;
      mem_addr        <= '0;
      mem_write_data  <= '0;
      ptr_q           <= '0;
      owner_q         <= '0;
      lsu_done        <= 1'b0;
    end else if (enable) begin
      if (grant_any) begin
        if (mem_read) mem_read_valid  <= 1'b1;
        else          mem_write_valid <= 1'b1;
        mem_addr <= rm_lane[grant_idx];
        if (!mem_read) mem_write_data <= rn_lane[grant_idx];
        owner_q <= grant_idx;
        ptr_q   <= lane_add(grant_idx, 1);
      end else if (ack_fire) begin
        mem_read_valid  <= 1'b0;
        mem_write_valid <= 1'b0;
      end
      lsu_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_lsu_multi_lane.sv
module tb_lsu_multi_lane;
  import lsu_multi_lane_pkg::*;

  localparam int NL = 4;
  localparam int DW = 64;
  localparam int AW = 7;
  localparam int MS = 1 << AW;

  logic             clk = 1'b0;
  logic             rst, enable, mem_read, mem_write;
  logic [2:0]       simd_state;
  logic [NL-1:0]    lane_mask;
  logic [NL*AW-1:0] rm_data;
  logic [NL*DW-1:0] rn_data;
  logic             mem_read_ack, mem_write_ack;
  logic [DW-1:0]    mem_read_data;
  logic             mem_read_valid, mem_write_valid, lsu_done;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_write_data;
  logic [NL*2-1:0]  lsu_state;
  logic [NL*DW-1:0] lsu_read_out;

  lsu_multi_lane #(.NUM_LANES(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .simd_state(simd_state),
    .mem_read(mem_read), .mem_write(mem_write), .lane_mask(lane_mask),
    .rm_data(rm_data), .rn_data(rn_data), .mem_read_ack(mem_read_ack),
    .mem_write_ack(mem_write_ack), .mem_read_data(mem_read_data),
    .mem_read_valid(mem_read_valid), .mem_write_valid(mem_write_valid),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .lsu_state(lsu_state),
    .lsu_read_out(lsu_read_out), .lsu_done(lsu_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory as seen by the responder (written by DUT stores) and the
  // reference model's own view of memory.
  logic [DW-1:0] mem     [MS];
  logic [DW-1:0] exp_mem [MS];
  logic [DW-1:0] exp_rd  [NL];
  int exp_ptr;
  int ack_delay;
  bit spurious, late_ack;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks the outstanding request after ack_delay cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_read_ack = 1'b0; mem_write_ack = 1'b0; mem_read_data = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_read_valid) begin
        if (wcnt >= ack_delay) begin
          mem_read_ack = 1'b1; mem_read_data = mem[mem_addr];
        end else begin
          wcnt++; mem_read_ack = 1'b0;
        end
        mem_write_ack = spurious;
      end else if (mem_write_valid) begin
        if (wcnt >= ack_delay) begin
          mem_write_ack = 1'b1; mem[mem_addr] = mem_write_data;
        end else begin
          wcnt++; mem_write_ack = 1'b0;
        end
        mem_read_ack = 1'b0;
      end else begin
        wcnt = 0;
        mem_read_ack  = late_ack;
        mem_write_ack = late_ack;
        if (late_ack) mem_read_data = 64'hBAD0_BAD0_BAD0_BAD0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [NL*AW-1:0] rand_rm();
    logic [NL*AW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*AW +: AW] = AW'($urandom_range(0, MS-1));
    return v;
  endfunction

  function automatic logic [NL*DW-1:0] rand_rn();
    logic [NL*DW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*DW +: DW] = {$urandom, $urandom};
    return v;
  endfunction

  function automatic logic [NL*DW-1:0] exp_rd_pack();
    logic [NL*DW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*DW +: DW] = exp_rd[i];
    return v;
  endfunction

  task automatic retire();
    @(negedge clk); simd_state = SIMD_UPDATE;
    @(negedge clk); simd_state = SIMD_IDLE;
    chk("retire_state", lsu_state, 0);
    chk("retire_done", lsu_done, 0);
  endtask

  // One full SIMD memory instruction, checked against the reference model:
  // active lanes are served in circular order starting at the model pointer.
  task automatic run_op(input logic [NL-1:0] mask, input bit rd, input bit wr, input int dly,
                        input logic [NL*AW-1:0] rm, input logic [NL*DW-1:0] rn);
    int q[$];
    int lane, budget, grants, exp_grants, held;
    bit prev_v, load;
    logic [AW-1:0] cur_addr;
    logic [NL*2-1:0] exp_st;
    load = rd;
    exp_st = '0;
    for (int k = 0; k < NL; k++) begin
      lane = (exp_ptr + k) % NL;
      if (mask[lane]) begin q.push_back(lane); exp_st[lane*2 +: 2] = 2'd3; end
    end
    exp_grants = q.size();
    @(negedge clk);
    rm_data = rm; rn_data = rn; lane_mask = mask; mem_read = rd; mem_write = wr;
    ack_delay = dly; simd_state = SIMD_REQUEST;
    @(negedge clk); simd_state = SIMD_WAIT;
    grants = 0; prev_v = 0; budget = 0; held = 0; cur_addr = '0;
    while (!lsu_done && budget < 200) begin
      @(posedge clk); #2; budget++;
      if ((mem_read_valid || mem_write_valid) && !prev_v) begin
        grants++; held = 1;
        if (q.size() == 0) chk("extra_grant", 1, 0);
        else begin
          lane = q.pop_front();
          cur_addr = rm[lane*AW +: AW];
          chk("grant_addr", mem_addr, cur_addr);
          chk("grant_is_read", mem_read_valid, load);
          chk("grant_is_write", mem_write_valid, !load);
          if (!load) chk("grant_wdata", mem_write_data, rn[lane*DW +: DW]);
          if (load) exp_rd[lane] = exp_mem[cur_addr];
          else      exp_mem[cur_addr] = rn[lane*DW +: DW];
          exp_ptr = (lane + 1) % NL;
        end
      end else if (mem_read_valid || mem_write_valid) begin
        held++;
        chk("addr_stable", mem_addr, cur_addr);
      end else if (prev_v) begin
        chk("valid_hold_cycles", held, dly + 1);
      end
      prev_v = mem_read_valid || mem_write_valid;
    end
    chk("done_reached", lsu_done, 1);
    chk("grant_count", grants, exp_grants);
    chk("done_lane_states", lsu_state, exp_st);
    chk("read_out", lsu_read_out, exp_rd_pack());
    retire();
  endtask

  initial begin
    logic [DW-1:0] v;
    rst = 1'b0; enable = 1'b1; simd_state = SIMD_IDLE; mem_read = 1'b0; mem_write = 1'b0;
    lane_mask = '0; rm_data = '0; rn_data = '0;
    ack_delay = 0; spurious = 0; late_ack = 0; exp_ptr = 0;
    for (int i = 0; i < NL; i++) exp_rd[i] = '0;
    for (int i = 0; i < MS; i++) begin v = {$urandom, $urandom}; mem[i] = v; exp_mem[i] = v; end
    mem[5] = 64'hDEAD; exp_mem[5] = 64'hDEAD;

    // Reset values
    repeat (3) @(posedge clk); #2;
    chk("rst_read_valid", mem_read_valid, 0);
    chk("rst_write_valid", mem_write_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_write_data, 0);
    chk("rst_state", lsu_state, 0);
    chk("rst_read_out", lsu_read_out, 0);
    chk("rst_done", lsu_done, 0);
    @(negedge clk); rst = 1'b1;

    // Four-lane store, lane order 0..3, then loads exercising the pointer wrap
    run_op(4'b1111, 0, 1, 0, {7'd3, 7'd2, 7'd1, 7'd0}, {64'd40, 64'd30, 64'd20, 64'd10});
    run_op(4'b1111, 1, 0, 0, {7'd0, 7'd1, 7'd2, 7'd3}, rand_rn());
    run_op(4'b1111, 1, 0, 0, rand_rm(), rand_rn());
    run_op(4'b1010, 1, 0, 0, rand_rm(), rand_rn());

    // Single load latency, lane 0 at address 5
    @(negedge clk);
    lane_mask = 4'b0001; rm_data = rand_rm(); rm_data[AW-1:0] = 7'd5;
    mem_read = 1; mem_write = 0; ack_delay = 0; simd_state = SIMD_REQUEST;
    @(posedge clk); #2;
    chk("lat_requesting", lsu_state, 8'h01);
    chk("lat_no_valid_yet", mem_read_valid, 0);
    @(negedge clk); simd_state = SIMD_WAIT;
    @(posedge clk); #2;
    chk("lat_valid", mem_read_valid, 1);
    chk("lat_addr", mem_addr, 5);
    @(posedge clk); #2;
    exp_rd[0] = exp_mem[5]; exp_ptr = 1;
    chk("lat_valid_drop", mem_read_valid, 0);
    chk("lat_read_out0", lsu_read_out[DW-1:0], 64'hDEAD);
    chk("lat_done", lsu_done, 1);
    chk("lat_state_done", lsu_state, 8'h03);
    retire();

    // enable=0 while WAITING: pending ack is not sampled
    @(negedge clk);
    lane_mask = 4'b0001; rm_data = rand_rm(); ack_delay = 0; simd_state = SIMD_REQUEST;
    @(negedge clk); simd_state = SIMD_WAIT;
    @(posedge clk); #2;
    chk("frz_valid", mem_read_valid, 1);
    enable = 1'b0;
    repeat (3) begin
      @(posedge clk); #2;
      chk("frz_valid_held", mem_read_valid, 1);
      chk("frz_waiting", lsu_state, 8'h02);
    end
    enable = 1'b1;
    @(posedge clk); #2;
    exp_rd[0] = exp_mem[rm_data[AW-1:0]]; exp_ptr = 1;
    chk("frz_release_done", lsu_state, 8'h03);
    chk("frz_read_out", lsu_read_out, exp_rd_pack());
    retire();

    // Ack stall with spurious write acks during loads
    spurious = 1;
    run_op(4'b1111, 1, 0, 5, rand_rm(), rand_rn());
    spurious = 0;

    // Both op bits set performs a load
    run_op(4'b0111, 1, 1, 1, rand_rm(), rand_rn());

    // All lanes masked: nothing happens, lsu_done stays low
    @(negedge clk);
    lane_mask = 4'b0000; mem_read = 1; mem_write = 0; simd_state = SIMD_REQUEST;
    repeat (4) begin
      @(posedge clk); #2;
      chk("mask0_no_valid", mem_read_valid | mem_write_valid, 0);
      chk("mask0_done", lsu_done, 0);
      chk("mask0_state", lsu_state, 0);
    end
    @(negedge clk); simd_state = SIMD_IDLE;

    // Randomized instructions
    for (int n = 0; n < 16; n++) begin
      int op;
      op = $urandom_range(0, 2);
      run_op(NL'($urandom_range(1, (1 << NL) - 1)), op != 1, op != 0,
             $urandom_range(0, 3), rand_rm(), rand_rn());
    end

    // Reset while lane 2 is WAITING, then a late ack after release
    @(negedge clk);
    lane_mask = 4'b0100; rm_data = rand_rm(); mem_read = 1; mem_write = 0;
    ack_delay = 50; simd_state = SIMD_REQUEST;
    @(negedge clk); simd_state = SIMD_WAIT;
    for (int n = 0; n < 10 && !mem_read_valid; n++) begin @(posedge clk); #2; end
    chk("mid_valid", mem_read_valid, 1);
    chk("mid_lane2_waiting", lsu_state, 8'h20);
    #1 rst = 1'b0;
    #1;
    chk("arst_read_valid", mem_read_valid, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_wdata", mem_write_data, 0);
    chk("arst_state", lsu_state, 0);
    chk("arst_read_out", lsu_read_out, 0);
    chk("arst_done", lsu_done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; ack_delay = 0; late_ack = 1; exp_ptr = 0;
    for (int i = 0; i < NL; i++) exp_rd[i] = '0;
    repeat (3) begin
      @(posedge clk); #2;
      chk("late_ack_state", lsu_state, 0);
      chk("late_ack_valid", mem_read_valid | mem_write_valid, 0);
    end
    late_ack = 0;
    chk("late_ack_read_out", lsu_read_out, 0);

    // Pointer restarts at lane 0 after reset
    run_op(4'b1111, 1, 0, 0, rand_rm(), rand_rn());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
